// File: rtl/fft_result_reader.sv
// fft_result_reader -- unload side of the FFT core.
//
// Once the core reports oRDY, this block walks the 4-bank x 2^ADDR_W result
// RAM. Bin k lives in bank k[1:0] at address k[ADDR_W+1:2]. One shared read
// address goes to all four banks. The block delays a tag (bin number) by the
// RAM read latency so the matching bank word can be picked. The word is then
// pushed into a small output FIFO, which drives a valid/ready stream carrying
// the bin value, its index and an end-of-frame flag.
//
// Reads are throttled by a credit check. Every read in flight already owns a
// FIFO slot, so the FIFO cannot overflow even when the sink stalls
// indefinitely.
//
// Build option: define FFT_READER_HALF_SPECTRUM_EN to unload only bins
// 0..N/2. With ADDR_W=9 that is 1025 bins instead of the full 2048-bin frame.

module fft_result_reader #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 9,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iSTART,
    input  logic              iFFT_RDY,
    output logic [ADDR_W-1:0] oADDR_RD,
    input  logic [DATA_W-1:0] iDATA_RE_0,
    input  logic [DATA_W-1:0] iDATA_RE_1,
    input  logic [DATA_W-1:0] iDATA_RE_2,
    input  logic [DATA_W-1:0] iDATA_RE_3,
    output logic [DATA_W-1:0] oDATA,
    output logic [ADDR_W+1:0] oBIN,
    output logic              oVALID,
    input  logic              iREADY,
    output logic              oLAST,
    output logic              oBUSY,
    output logic              oDONE
);

    localparam int BIN_W = ADDR_W + 2;

`ifdef FFT_READER_HALF_SPECTRUM_EN
    // Real input gives a conjugate-symmetric spectrum; bins 0..N/2 suffice.
    localparam int NBIN = 2 ** (ADDR_W + 1) + 1;
`else
    localparam int NBIN = 2 ** (ADDR_W + 2);
`endif

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NBIN - 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_READ,
        ST_DRAIN
    } state_t;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [BIN_W-1:0]    bin_q, bin_d;       // next bin to issue
    logic [ADDR_W-1:0]   addr_q, addr_d;     // shared RAM read address
    logic                done_q, done_d;

    // Tag pipeline: stage 0 is loaded with the read issue, and stage RD_LAT
    // lines up with the cycle in which that read's data is valid on iDATA_RE_n.
    logic                pipe_vld_q [RD_LAT+1];
    logic [BIN_W-1:0]    pipe_bin_q [RD_LAT+1];

    // Output FIFO.
    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [BIN_W-1:0]    fifo_bin_q  [FIFO_DEPTH];
    logic                fifo_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                issue;
    logic                push;
    logic                pop;
    logic                fifo_nonempty;
    logic                head_last;
    logic [OCC_W-1:0]    inflight;
    logic [OCC_W-1:0]    occupancy;
    logic                credit_ok;
    logic [DATA_W-1:0]   bank_word;
    logic [BIN_W-1:0]    land_bin;

    assign fifo_nonempty = (count_q != '0);
    assign pop           = fifo_nonempty & iREADY;
    assign push          = pipe_vld_q[RD_LAT];
    assign land_bin      = pipe_bin_q[RD_LAT];
    assign head_last     = fifo_last_q[rd_ptr_q];

    // Count the reads in flight (all tag stages, including the one landing now).
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            inflight = inflight + OCC_W'(pipe_vld_q[i]);
        end
    end

    // Credit: every outstanding read plus every buffered word must fit in the
    // FIFO. A pop at this same edge frees a slot. Without counting that slot,
    // full-rate streaming would stall every few cycles.
    assign occupancy = OCC_W'(count_q) + inflight;
    assign credit_ok = occupancy < (OCC_W'(FIFO_DEPTH) + OCC_W'(pop));

    // Select the bank word for the bin whose data is valid this cycle.
    always_comb begin
        bank_word = iDATA_RE_0;
        case (land_bin[1:0])
            2'd0:    bank_word = iDATA_RE_0;
            2'd1:    bank_word = iDATA_RE_1;
            2'd2:    bank_word = iDATA_RE_2;
            default: bank_word = iDATA_RE_3;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: next state, read issue and done pulse
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        bin_d   = bin_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        issue   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d = ST_WAIT_RDY;
                    bin_d   = '0;
                end
            end
            ST_WAIT_RDY: begin
                // The first read goes out on the same edge that enters READ,
                // so data reaches the stream RD_LAT+1 cycles into READ.
                issue = iFFT_RDY & credit_ok;
            end
            ST_READ: begin
                issue = credit_ok;
            end
            ST_DRAIN: begin
                // The last bin is also the newest one, so when it is accepted
                // the FIFO and the tag pipeline are both empty.
                if (pop && head_last && (inflight == '0)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            addr_d  = bin_q[BIN_W-1:2];
            bin_d   = bin_q + BIN_W'(1);
            state_d = (bin_q == LAST_BIN) ? ST_DRAIN : ST_READ;
        end
    end

    // FIFO occupancy bookkeeping; push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Control registers: FSM state, issue counter, read address, done pulse.
    always_ff @(posedge iCLK or negedge iRESET) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before the edge, regardless of statement order.
        if (!iRESET) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    // Tag shift register that tracks the RAM read latency.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_bin_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= issue;
            pipe_bin_q[0] <= bin_q;
            for (int i = 1; i <= RD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_bin_q[i] <= pipe_bin_q[i-1];
            end
        end
    end

    // FIFO pointers and count.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage write.
    // NOTE: the storage array is deliberately not reset. Its entries are only
    // observed behind count_q, which is reset, so clearing it would add reset
    // fan-out for nothing.
    always_ff @(posedge iCLK) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= bank_word;
            fifo_bin_q[wr_ptr_q]  <= land_bin;
            fifo_last_q[wr_ptr_q] <= (land_bin == LAST_BIN);
        end
    end

    // ------------------------------------------------------------------
    // Outputs: the stream fields are forced to 0 while empty, so all
    // outputs read 0 in and right after reset.
    // ------------------------------------------------------------------
    assign oADDR_RD = addr_q;
    assign oVALID   = fifo_nonempty;
    assign oDATA    = fifo_nonempty ? fifo_data_q[rd_ptr_q] : '0;
    assign oBIN     = fifo_nonempty ? fifo_bin_q[rd_ptr_q]  : '0;
    assign oLAST    = fifo_nonempty & head_last;
    assign oBUSY    = (state_q != ST_IDLE);
    assign oDONE    = done_q;

endmodule

// File: tb/tb_fft_result_reader.sv
// Testbench for fft_result_reader: behavioural RAM (word = bank*1000 + addr,
// two-cycle registered read), expected-bin scoreboard, and a negedge monitor.
// Define FFT_READER_HALF_SPECTRUM_EN for both files to cover the half-spectrum build.

module tb_fft_result_reader;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 9;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;
`ifdef FFT_READER_HALF_SPECTRUM_EN
    localparam int NBIN = 1025;
`else
    localparam int NBIN = 2048;
`endif

    logic              iCLK = 1'b0;
    logic              iRESET;
    logic              iSTART;
    logic              iFFT_RDY;
    logic [ADDR_W-1:0] oADDR_RD;
    logic [DATA_W-1:0] iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3;
    logic [DATA_W-1:0] oDATA;
    logic [ADDR_W+1:0] oBIN;
    logic              oVALID;
    logic              iREADY;
    logic              oLAST;
    logic              oBUSY;
    logic              oDONE;

    fft_result_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iFFT_RDY(iFFT_RDY),
        .oADDR_RD(oADDR_RD),
        .iDATA_RE_0(iDATA_RE_0), .iDATA_RE_1(iDATA_RE_1),
        .iDATA_RE_2(iDATA_RE_2), .iDATA_RE_3(iDATA_RE_3),
        .oDATA(oDATA), .oBIN(oBIN), .oVALID(oVALID), .iREADY(iREADY),
        .oLAST(oLAST), .oBUSY(oBUSY), .oDONE(oDONE)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    // Result RAM model: address registered, then data registered.
    logic [ADDR_W-1:0] ram_a_q;
    always @(posedge iCLK) begin
        ram_a_q    <= oADDR_RD;
        iDATA_RE_0 <= DATA_W'(32'd0    + 32'(ram_a_q));
        iDATA_RE_1 <= DATA_W'(32'd1000 + 32'(ram_a_q));
        iDATA_RE_2 <= DATA_W'(32'd2000 + 32'(ram_a_q));
        iDATA_RE_3 <= DATA_W'(32'd3000 + 32'(ram_a_q));
    end

    typedef struct {
        int unsigned bin;
        int unsigned data;
        bit          last;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   beats = 0;
    int   done_cnt = 0;
    int   last_xfer_cyc = 0;
    bit   rand_ready = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input int budget);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound of %0d cycles expired (cycle %0d)", name, budget, cyc);
    endtask

    // Expected frame: bin k comes from bank k%4, address k/4.
    task automatic push_frame();
        exp_t e;
        beats = 0;
        for (int k = 0; k < NBIN; k++) begin
            e.bin  = k;
            e.data = (k % 4) * 1000 + k / 4;
            e.last = (k == NBIN - 1);
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(posedge iCLK); #1 iSTART = 1'b1;
        @(posedge iCLK); #1 iSTART = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int done_cyc);
        bit seen = 0;
        done_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge iCLK);
            if (oDONE) begin
                seen = 1;
                done_cyc = cyc;
                break;
            end
        end
        if (!seen) begin
            fail_now("done_timeout", budget);
        end else begin
            check("done_after_last", done_cyc - last_xfer_cyc, 1);
            check("frame_beats", beats, NBIN);
            check("sb_empty", sb.size(), 0);
            @(negedge iCLK);
            check("done_width", oDONE, 0);
            check("busy_after_done", oBUSY, 0);
        end
    endtask

    // Random sink backpressure: ready about 30% of cycles.
    always @(posedge iCLK) begin
        if (rand_ready) begin
            #1 iREADY = ($urandom_range(0, 99) < 30);
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks that the
    // stream holds steady while stalled.
    logic              prev_stall = 0;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W+1:0] prev_bin;
    logic              prev_last;
    always @(negedge iCLK) begin
        exp_t e;
        if (!iRESET) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", oVALID, 1);
                check("stall_data", oDATA, prev_data);
                check("stall_bin", oBIN, prev_bin);
                check("stall_last", oLAST, prev_last);
            end
            if (oDONE) done_cnt++;
            if (oVALID && iREADY) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: bin %0d data %0d with nothing expected", oBIN, oDATA);
                end else begin
                    e = sb.pop_front();
                    check("beat_bin", oBIN, e.bin);
                    check("beat_data", oDATA, e.data);
                    check("beat_last", oLAST, e.last);
                    beats++;
                    if (oLAST) last_xfer_cyc = cyc;
                end
            end
            prev_stall = oVALID && !iREADY;
            prev_data  = oDATA;
            prev_bin   = oBIN;
            prev_last  = oLAST;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int first_cyc;
        int done_cyc;
        int rel_cyc;
        int d0;
        bit hit;

        // Reset state, with start and ready asserted during reset.
        iRESET = 1'b0; iSTART = 1'b1; iFFT_RDY = 1'b1; iREADY = 1'b0;
        repeat (3) @(negedge iCLK);
        check("rst_valid", oVALID, 0);
        check("rst_busy", oBUSY, 0);
        check("rst_addr", oADDR_RD, 0);
        check("rst_done", oDONE, 0);
        check("rst_last", oLAST, 0);
        @(posedge iCLK); #1 iRESET = 1'b1; iSTART = 1'b0; iFFT_RDY = 1'b0;

        // Frame 1: wait for the core, then full-rate streaming.
        // iSTART in READ and iFFT_RDY dropping mid-frame must be ignored.
        iREADY = 1'b1;
        push_frame();
        pulse_start();
        repeat (10) @(negedge iCLK);
        check("wait_rdy_busy", oBUSY, 1);
        check("wait_rdy_valid", oVALID, 0);
        @(posedge iCLK); #1 iFFT_RDY = 1'b1;
        @(posedge iCLK);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge iCLK);
            if (oVALID) break;
            @(posedge iCLK);
            lat++;
        end
        check("first_valid_latency", lat, RD_LAT + 1);
        first_cyc = cyc;
        repeat (100) @(posedge iCLK);
        #1 iSTART = 1'b1; iFFT_RDY = 1'b0;
        @(posedge iCLK); #1 iSTART = 1'b0;
        wait_done(NBIN + 100, done_cyc);
        check("full_rate_span", done_cyc - first_cyc, NBIN);

        // Frame 2: random 30% backpressure.
        iFFT_RDY = 1'b1;
        push_frame();
        rand_ready = 1'b1;
        pulse_start();
        wait_done(NBIN * 8, done_cyc);
        rand_ready = 1'b0;

        // Frame 3: sink stalled 50 cycles; the FIFO fills to depth, then the
        // address freezes and the stream resumes without a gap.
        @(posedge iCLK); #1 iREADY = 1'b0;
        push_frame();
        pulse_start();
        repeat (50) @(negedge iCLK);
        check("stall_fill_valid", oVALID, 1);
        check("stall_fill_bin", oBIN, 0);
        check("stall_fill_data", oDATA, 0);
        check("stall_addr_frozen", oADDR_RD, (FIFO_DEPTH - 1) / 4);
        @(posedge iCLK); #1 iREADY = 1'b1;
        rel_cyc = cyc;
        wait_done(NBIN + 100, done_cyc);
        check("resume_span", done_cyc - rel_cyc, NBIN);

        // Frame 4: reset at bin 700 aborts with no oDONE. A new iSTART is
        // needed, and the restart begins at bin 0.
        push_frame();
        pulse_start();
        hit = 0;
        for (int i = 0; i < NBIN + 100; i++) begin
            @(posedge iCLK); #1;
            if (beats >= 700) begin
                hit = 1;
                break;
            end
        end
        if (!hit) fail_now("reach_bin_700", NBIN + 100);
        iRESET = 1'b0;
        #1;
        check("abort_valid", oVALID, 0);
        check("abort_busy", oBUSY, 0);
        check("abort_addr", oADDR_RD, 0);
        check("abort_data", oDATA, 0);
        check("abort_bin", oBIN, 0);
        check("abort_last", oLAST, 0);
        sb.delete();
        d0 = done_cnt;
        repeat (5) @(negedge iCLK);
        @(posedge iCLK); #1 iRESET = 1'b1;
        repeat (10) @(negedge iCLK);
        check("abort_no_done", done_cnt, d0);
        check("abort_stays_idle", oBUSY, 0);
        check("abort_no_stream", oVALID, 0);
        push_frame();
        pulse_start();
        wait_done(NBIN + 100, done_cyc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
